regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Single-port write arbiter and scoreboard in front of the backend regfile.
- Shares the one regfile write port between three sources: the in-order pipeline WB stage, the multi-cycle mul/div unit (MDU) and the load/store return path (LSU).
- Tracks destination registers of in-flight long-latency ops so the hazard unit can stall dependent reads.
- Guarantees forward progress of long-latency results by stalling the pipeline when they starve.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a valid MDU/LSU request may go ungranted before the pipeline is stalled (1..7).
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
pipe_wb_valid  in  1  pipeline WB write request (no backpressure except via pipe_stall)
pipe_wb_rd  in  5  pipeline destination index
pipe_wb_data  in  32  pipeline write data
pipe_stall  out  1  pipeline must freeze and hold its WB request this cycle
mdu_valid  in  1  MDU result valid
mdu_rd  in  5  MDU destination
mdu_data  in  32  MDU result
mdu_ready  out  1  MDU result accepted this cycle
lsu_valid  in  1  load return valid
lsu_rd  in  5  load destination
lsu_data  in  32  load data
lsu_ready  out  1  load return accepted this cycle
issue_valid  in  1  long-latency op issuing this cycle
issue_rd  in  5  its destination
issue_accept  out  1  issue allowed (scoreboard slot free)
rs1_index  in  5  decode source 1
rs2_index  in  5  decode source 2
rs1_busy  out  1  rs1 has a pending long-latency write
rs2_busy  out  1  rs2 has a pending long-latency write
rf_write_enable  out  1  to regfile write_enable
rf_rd_index  out  5  to regfile rd_index
rf_write_data  out  32  to regfile write_data

Behaviour:
- Reset (rst_n low at posedge):
  - rf_write_enable=0, rf_rd_index=0, rf_write_data=0.
  - Scoreboard busy[31:0]=0; starve_cnt=0; round-robin pointer=MDU.
  - While rst_n is low, all combinational outputs are forced to 0: mdu_ready, lsu_ready, pipe_stall, issue_accept, rs*_busy.
  - Mid-operation reset drops all in-flight tracking. Requesters keep their valids asserted and are served after release.
- Handshake: a requester holds valid/rd/data stable until ready=1. A transfer occurs on valid&&ready at posedge. ready never asserts without valid.
- Pipeline request: counts as a request only if pipe_wb_valid && pipe_wb_rd!=0.
- Grant (combinational, one grant per cycle):
  - If starve_cnt>=STARVE_LIMIT and (mdu_valid||lsu_valid): pipe_stall=1 and the long requester chosen by round-robin is granted. The pipeline is not granted.
  - Else if a pipeline request exists: grant the pipeline. mdu_ready=lsu_ready=0, pipe_stall=0.
  - Else grant MDU/LSU by round-robin. A single valid requester is granted directly.
- Round-robin: after an MDU grant the pointer moves to LSU; after an LSU grant it moves to MDU. A pipeline grant leaves the pointer unchanged.
- starve_cnt:
  - Clears on any MDU/LSU grant.
  - Else increments (saturating at STARVE_LIMIT) if mdu_valid||lsu_valid.
  - Else clears.
- Write port:
  - The granted rd/data is registered into rf_rd_index/rf_write_data at posedge. Latency exactly 1 cycle from grant to rf_write_enable=1.
  - rf_write_enable=1 for that cycle only if the granted rd!=0.
  - MDU/LSU transfers with rd=0 are accepted and discarded.
  - With no grant, rf_write_enable=0 and index/data hold their previous values.
- Scoreboard:
  - issue_accept = issue_valid && (issue_rd==0 || !busy[issue_rd] || rd cleared by a long grant this cycle).
  - Accept with rd!=0 sets busy[rd].
  - An MDU/LSU transfer clears busy[rd]. If the same rd is cleared and set in one cycle, set wins (busy stays 1).
  - busy[0] is always 0.
- rsN_busy = busy[rsN_index]; index 0 always reads 0.
- busy clears at the grant edge, the cycle the write reaches the regfile. The regfile's WB forwarding covers a reader in that cycle.
- A pipeline WB to a busy rd is a hazard-unit protocol error. The write is performed and busy is unchanged.

Test Plan:
- Reset: hold rst_n=0 with all valids=1 -> all outputs 0. Release -> first cycle grants pipeline if pipeline valid.
- Pipeline only, rd=5, data=0xDEADBEEF -> next cycle rf_write_enable=1, rf_rd_index=5, rf_write_data=0xDEADBEEF. Pipeline rd=0 -> rf_write_enable=0.
- MDU and LSU valid together, no pipeline -> MDU granted first, LSU next cycle, writes on consecutive cycles in that order.
- Pipeline valid every cycle plus MDU valid, STARVE_LIMIT=4 -> pipe_stall=1 and mdu_ready=1 on the 5th cycle; starve_cnt returns to 0.
- Issue rd=7 -> rs1_index=7 gives rs1_busy=1. A second issue to rd=7 -> issue_accept=0. LSU returns rd=7 alongside a new issue rd=7 -> both accepted, busy[7] stays 1.
- issue rd=0 -> accepted with no busy bit set. LSU rd=0 -> lsu_ready=1 and rf_write_enable=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Single regfile write port shared by pipeline WB, MDU and LSU, with a busy
// scoreboard for long-latency destinations and a starvation stall for the pipeline.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_accept,
    input  logic [4:0]  rs1_index,
    input  logic [4:0]  rs2_index,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_write_enable,
    output logic [4:0]  rf_rd_index,
    output logic [31:0] rf_write_data
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;

    typedef enum logic { RR_MDU = 1'b0, RR_LSU = 1'b1 } rr_e;

    rr_e               rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              grant_valid;
    logic              long_grant;
    logic [REG_W-1:0]  grant_rd;
    logic [DATA_W-1:0] grant_data;
    logic              pipe_req;
    logic              long_any;
    logic              starved;
    logic              pick_mdu;

    // Grant selection, starvation counter, scoreboard update and hazard outputs.
    always_comb begin
        mdu_ready    = 1'b0;
        lsu_ready    = 1'b0;
        pipe_stall   = 1'b0;
        issue_accept = 1'b0;
        rs1_busy     = 1'b0;
        rs2_busy     = 1'b0;
        grant_valid  = 1'b0;
        long_grant   = 1'b0;
        grant_rd     = '0;
        grant_data   = '0;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;

        pipe_req = pipe_wb_valid && (pipe_wb_rd != '0);
        long_any = mdu_valid || lsu_valid;
        starved  = long_any && (cnt_q >= CNT_W'(STARVE_LIMIT));
        pick_mdu = mdu_valid && (!lsu_valid || (rr_q == RR_MDU));

        if (rst_n) begin
            if (long_any && (starved || !pipe_req)) begin
                long_grant  = 1'b1;
                grant_valid = 1'b1;
                pipe_stall  = starved;
                if (pick_mdu) begin
                    mdu_ready  = 1'b1;
                    grant_rd   = mdu_rd;
                    grant_data = mdu_data;
                    rr_d       = RR_LSU;
                end else begin
                    lsu_ready  = 1'b1;
                    grant_rd   = lsu_rd;
                    grant_data = lsu_data;
                    rr_d       = RR_MDU;
                end
            end else if (pipe_req) begin
                grant_valid = 1'b1;
                grant_rd    = pipe_wb_rd;
                grant_data  = pipe_wb_data;
            end

            if (long_grant) begin
                cnt_d = '0;
            end else if (long_any) begin
                cnt_d = (cnt_q >= CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
            end

            // A slot freed by this cycle's long grant may be re-issued immediately.
            issue_accept = issue_valid && ((issue_rd == '0) || !busy_q[issue_rd] ||
                                           (long_grant && (grant_rd == issue_rd)));
            if (long_grant) begin
                busy_d[grant_rd] = 1'b0;
            end
            if (issue_accept) begin
                busy_d[issue_rd] = 1'b1;
            end
            busy_d[0] = 1'b0;

            rs1_busy = busy_q[rs1_index];
            rs2_busy = busy_q[rs2_index];
        end
    end

    // State and regfile write-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q            <= RR_MDU;
            cnt_q           <= '0;
            busy_q          <= '0;
            rf_write_enable <= 1'b0;
            rf_rd_index     <= '0;
            rf_write_data   <= '0;
        end else begin
            rr_q            <= rr_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            rf_write_enable <= grant_valid && (grant_rd != '0);
            if (grant_valid) begin
                rf_rd_index   <= grant_rd;
                rf_write_data <= grant_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_accept;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_rd_index;
    logic [31:0] rf_write_data;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_accept(issue_accept),
        .rs1_index(rs1_index), .rs2_index(rs2_index), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_write_enable(rf_write_enable), .rf_rd_index(rf_rd_index), .rf_write_data(rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model state: what the regfile port and scoreboard must look like.
    bit [31:0] m_busy = '0;
    int        m_cnt = 0;
    bit        m_ptr_lsu = 1'b0;
    bit        m_we = 1'b0;
    bit [4:0]  m_idx = '0;
    bit [31:0] m_data = '0;
    bit        mdu_done = 1'b0;
    bit        lsu_done = 1'b0;
    bit        pipe_done = 1'b0;

    always @(negedge clk) begin : model
        int        g;
        bit        lv, preq, e_stall, e_acc;
        bit [4:0]  grd;
        bit [31:0] gdat;

        chk("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
        chk("rf_rd_index", 32'(rf_rd_index), 32'(m_idx));
        chk("rf_write_data", rf_write_data, m_data);

        g = 0; e_stall = 1'b0; e_acc = 1'b0; grd = '0; gdat = '0;
        lv   = mdu_valid || lsu_valid;
        preq = pipe_wb_valid && (pipe_wb_rd != 5'd0);
        if (rst_n) begin
            // g: 0 none, 1 pipeline, 2 MDU, 3 LSU
            if (lv && (m_cnt >= LIMIT || !preq)) begin
                e_stall = (m_cnt >= LIMIT);
                g = (mdu_valid && (!lsu_valid || !m_ptr_lsu)) ? 2 : 3;
            end else if (preq) begin
                g = 1;
            end
            case (g)
                1: begin grd = pipe_wb_rd; gdat = pipe_wb_data; end
                2: begin grd = mdu_rd;     gdat = mdu_data;     end
                3: begin grd = lsu_rd;     gdat = lsu_data;     end
                default: ;
            endcase
            e_acc = issue_valid && (issue_rd == 5'd0 || !m_busy[issue_rd] ||
                                    (g >= 2 && grd == issue_rd));
        end

        chk("mdu_ready", 32'(mdu_ready), 32'(g == 2));
        chk("lsu_ready", 32'(lsu_ready), 32'(g == 3));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
        chk("issue_accept", 32'(issue_accept), 32'(e_acc));
        chk("rs1_busy", 32'(rs1_busy), 32'(rst_n && m_busy[rs1_index]));
        chk("rs2_busy", 32'(rs2_busy), 32'(rst_n && m_busy[rs2_index]));

        mdu_done  = (g == 2);
        lsu_done  = (g == 3);
        pipe_done = rst_n && pipe_wb_valid && !e_stall;

        if (!rst_n) begin
            m_busy = '0; m_cnt = 0; m_ptr_lsu = 1'b0;
            m_we = 1'b0; m_idx = '0; m_data = '0;
        end else begin
            m_we = (g != 0) && (grd != 5'd0);
            if (g != 0) begin m_idx = grd; m_data = gdat; end
            if (g >= 2 && grd != 5'd0) m_busy[grd] = 1'b0;
            if (e_acc && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (g >= 2) m_cnt = 0;
            else if (lv) m_cnt = (m_cnt >= LIMIT) ? LIMIT : m_cnt + 1;
            else m_cnt = 0;
            if (g == 2) m_ptr_lsu = 1'b1;
            if (g == 3) m_ptr_lsu = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h0000_0333;
        mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h0000_0111;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0000_0222;
        issue_valid = 1'b1; issue_rd = 5'd4;
        rs1_index = 5'd4; rs2_index = 5'd4;

        // Reset with every requester asserted.
        repeat (3) tick();
        at_neg();
        chk("rst mdu_ready", 32'(mdu_ready), 32'd0);
        chk("rst lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst pipe_stall", 32'(pipe_stall), 32'd0);
        chk("rst issue_accept", 32'(issue_accept), 32'd0);
        chk("rst rs1_busy", 32'(rs1_busy), 32'd0);
        chk("rst rf_we", 32'(rf_write_enable), 32'd0);
        chk("rst rf_data", rf_write_data, 32'd0);

        // Release: pipeline first, then MDU, then LSU.
        tick(); rst_n = 1'b1;
        at_neg();
        chk("rel mdu_ready", 32'(mdu_ready), 32'd0);
        chk("rel pipe_stall", 32'(pipe_stall), 32'd0);
        chk("rel issue_accept", 32'(issue_accept), 32'd1);
        tick();
        chk("rel rf_we", 32'(rf_write_enable), 32'd1);
        chk("rel rf_idx", 32'(rf_rd_index), 32'd3);
        pipe_wb_valid = 1'b0; issue_valid = 1'b0;
        at_neg();
        chk("rr mdu_ready", 32'(mdu_ready), 32'd1);
        chk("rr lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rs2_busy rd4", 32'(rs2_busy), 32'd1);
        tick();
        chk("rr rf_idx mdu", 32'(rf_rd_index), 32'd1);
        mdu_valid = 1'b0;
        at_neg();
        chk("rr lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        chk("rr rf_idx lsu", 32'(rf_rd_index), 32'd2);
        chk("rr rf_data lsu", rf_write_data, 32'h0000_0222);
        lsu_valid = 1'b0;

        // Pipeline-only writes, including rd=0.
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hDEADBEEF;
        tick();
        chk("pipe rf_we", 32'(rf_write_enable), 32'd1);
        chk("pipe rf_idx", 32'(rf_rd_index), 32'd5);
        chk("pipe rf_data", rf_write_data, 32'hDEADBEEF);
        pipe_wb_rd = 5'd0; pipe_wb_data = 32'h1234_5678;
        tick();
        chk("pipe rd0 rf_we", 32'(rf_write_enable), 32'd0);
        chk("pipe rd0 hold data", rf_write_data, 32'hDEADBEEF);

        // Starvation: MDU waits behind a busy pipeline, wins on the 5th cycle.
        pipe_wb_rd = 5'd9; pipe_wb_data = 32'h0000_0999;
        mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'h0000_0BBB;
        for (int k = 0; k < LIMIT; k++) begin
            at_neg();
            chk("starve early stall", 32'(pipe_stall), 32'd0);
            tick();
        end
        at_neg();
        chk("starve stall", 32'(pipe_stall), 32'd1);
        chk("starve mdu_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk("starve rf_idx", 32'(rf_rd_index), 32'd11);
        mdu_valid = 1'b0;
        at_neg();
        chk("starve cleared", 32'(pipe_stall), 32'd0);
        tick();
        chk("starve pipe write", 32'(rf_rd_index), 32'd9);
        pipe_wb_valid = 1'b0;

        // Scoreboard set/clear on rd=7.
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_index = 5'd7;
        at_neg();
        chk("sb first accept", 32'(issue_accept), 32'd1);
        tick();
        at_neg();
        chk("sb rs1_busy", 32'(rs1_busy), 32'd1);
        chk("sb second reject", 32'(issue_accept), 32'd0);
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
        at_neg();
        chk("sb lsu_ready", 32'(lsu_ready), 32'd1);
        chk("sb reissue accept", 32'(issue_accept), 32'd1);
        tick();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        chk("sb lsu write", 32'(rf_rd_index), 32'd7);
        at_neg();
        chk("sb set wins", 32'(rs1_busy), 32'd1);

        // rd=0 issue and LSU return.
        tick();
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_index = 5'd0;
        at_neg();
        chk("rd0 issue accept", 32'(issue_accept), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("rd0 rs1_busy", 32'(rs1_busy), 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0AAA;
        at_neg();
        chk("rd0 lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        chk("rd0 lsu rf_we", 32'(rf_write_enable), 32'd0);
        lsu_valid = 1'b0;

        // Randomized traffic; requesters hold until accepted.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 149) != 0);
            if (!pipe_wb_valid || pipe_done) begin
                pipe_wb_valid = ($urandom_range(0, 3) != 0);
                pipe_wb_rd    = 5'($urandom_range(0, 31));
                pipe_wb_data  = $urandom();
            end
            if (!mdu_valid || mdu_done) begin
                mdu_valid = ($urandom_range(0, 2) == 0);
                mdu_rd    = 5'($urandom_range(0, 15));
                mdu_data  = $urandom();
            end
            if (!lsu_valid || lsu_done) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = 5'($urandom_range(0, 15));
                lsu_data  = $urandom();
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 15));
            rs1_index   = 5'($urandom_range(0, 15));
            rs2_index   = 5'($urandom_range(0, 31));
        end

        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
